// File: rtl/ledpanel_write_arbiter_if.sv
// Requester-side write bus for the LED panel write arbiter: per-requester
// valid/ready/last handshake plus packed colour-plane enables, address and data.
interface ledpanel_write_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ*4-1:0]  req_wr;
    logic [NUM_REQ*16-1:0] req_addr;
    logic [NUM_REQ*24-1:0] req_wdat;
    logic [NUM_REQ-1:0]    req_ready;

    modport master (
        output req_valid, req_last, req_wr, req_addr, req_wdat,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_last, req_wr, req_addr, req_wdat,
        output req_ready
    );
endinterface

// File: rtl/ledpanel_write_arbiter.sv
// Round-robin, burst-locked arbiter for the LED panel colour-memory write port.
// Define LEDPANEL_ARB_STATS_EN to add saturating write/drop statistics outputs.
module ledpanel_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CHAINED = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                       ctrl_clk,
    input  logic                       ctrl_rst,
    ledpanel_write_arbiter_if.slave    req_if,
    output logic                       ctrl_en,
    output logic [3:0]                 ctrl_wr,
    output logic [15:0]                ctrl_addr,
    output logic [23:0]                ctrl_wdat,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       drop_pulse
`ifdef LEDPANEL_ARB_STATS_EN
    ,
    output logic [15:0]                stat_writes,
    output logic [15:0]                stat_drops
`endif
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST    = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [16:0]   ADDR_LIMIT = 17'(CHAINED * 128);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          drop_q, drop_d;
    logic [2:0]    wr_q, wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [23:0]   wdat_q, wdat_d;

    logic          own_valid, own_last, in_range, xfer, timeout_hit;
    logic [2:0]    own_wr;
    logic [15:0]   own_addr;
    logic [23:0]   own_wdat;
    logic [IW-1:0] pick;
    int            rr_idx;

    always_comb begin : owner_mux
        own_valid = req_if.req_valid[owner_q];
        own_last  = req_if.req_last[owner_q];
        own_wr    = req_if.req_wr[owner_q*4 +: 3];
        own_addr  = req_if.req_addr[owner_q*16 +: 16];
        own_wdat  = req_if.req_wdat[owner_q*24 +: 24];
    end

    // Walk downward so the index nearest ptr+1 is the last (winning) assignment.
    always_comb begin : rr_pick
        pick   = ptr_q;
        rr_idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = (int'(ptr_q) + k) % NUM_REQ;
            if (req_if.req_valid[rr_idx]) pick = IW'(rr_idx);
        end
    end

    assign in_range    = {1'b0, own_addr} < ADDR_LIMIT;
    assign xfer        = (state_q == LOCKED) && own_valid;
    assign timeout_hit = (TIMEOUT > 0) && (state_q == LOCKED) && !own_valid && (cnt_q == TO_LAST);

    // NOTE: every next-state signal gets its hold/default value first, so no
    // path through the case below can leave one unassigned and infer a latch.
    always_comb begin : fsm_next
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        drop_d  = 1'b0;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        case (state_q)
            IDLE: begin
                if (|req_if.req_valid) begin
                    state_d = LOCKED;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    cnt_d  = '0;
                    wr_d   = own_wr;
                    addr_d = own_addr;
                    wdat_d = own_wdat;
                    en_d   = in_range;
                    drop_d = !in_range;
                    if (own_last) begin
                        state_d = IDLE;
                        ptr_d   = owner_q;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    ptr_d   = owner_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            en_q    <= 1'b0;
            drop_q  <= 1'b0;
            wr_q    <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
        end
    end

    assign grant            = (state_q == LOCKED) ? (NUM_REQ'(1) << owner_q) : '0;
    assign req_if.req_ready = grant;
    assign ctrl_en          = en_q;
    assign drop_pulse       = drop_q;
    assign ctrl_wr          = {1'b0, wr_q};
    assign ctrl_addr        = addr_q;
    assign ctrl_wdat        = wdat_q;

`ifdef LEDPANEL_ARB_STATS_EN
    logic [15:0] stat_writes_q, stat_drops_q;

    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            stat_writes_q <= '0;
            stat_drops_q  <= '0;
        end else begin
            if (en_d && (stat_writes_q != 16'hFFFF)) stat_writes_q <= stat_writes_q + 16'd1;
            if (drop_d && (stat_drops_q != 16'hFFFF)) stat_drops_q <= stat_drops_q + 16'd1;
        end
    end

    assign stat_writes = stat_writes_q;
    assign stat_drops  = stat_drops_q;
`endif
endmodule

// File: tb/tb_ledpanel_write_arbiter.sv
// Scoreboard bench for ledpanel_write_arbiter: per-requester beat drivers push
// expected panel writes on handshake; a monitor pops them as the DUT writes.
module tb_ledpanel_write_arbiter;
    localparam int NR = 2;

    typedef struct packed {
        logic [15:0] addr;
        logic [23:0] wdat;
        logic [3:0]  wr;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        en;
        logic        drop;
        logic [3:0]  wr;
        logic [15:0] addr;
        logic [23:0] wdat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic          ctrl_en, drop_pulse;
    logic [3:0]    ctrl_wr;
    logic [15:0]   ctrl_addr;
    logic [23:0]   ctrl_wdat;
    logic [NR-1:0] grant;
`ifdef LEDPANEL_ARB_STATS_EN
    logic [15:0]   stat_writes, stat_drops;
`endif

    ledpanel_write_arbiter_if #(.NUM_REQ(NR)) rif ();

    ledpanel_write_arbiter #(.NUM_REQ(NR), .CHAINED(3), .TIMEOUT(4)) dut (
        .ctrl_clk   (clk),
        .ctrl_rst   (rst),
        .req_if     (rif),
        .ctrl_en    (ctrl_en),
        .ctrl_wr    (ctrl_wr),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdat  (ctrl_wdat),
        .grant      (grant),
        .drop_pulse (drop_pulse)
`ifdef LEDPANEL_ARB_STATS_EN
        ,
        .stat_writes(stat_writes),
        .stat_drops (stat_drops)
`endif
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t beat_q [NR][$];
    exp_t  sb [$];
    bit    accepted [NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int addr, input int wdat, input logic [3:0] wr, input logic last);
        beat_t b;
        b.addr = addr[15:0];
        b.wdat = wdat[23:0];
        b.wr   = wr;
        b.last = last;
        return b;
    endfunction

    function automatic exp_t expect_of(input beat_t b);
        exp_t e;
        e.en   = (b.addr < 16'd384);
        e.drop = !e.en;
        e.wr   = {1'b0, b.wr[2:0]};
        e.addr = b.addr;
        e.wdat = b.wdat;
        return e;
    endfunction

    // Driver: retire accepted beats after the edge, then present the next head.
    initial begin
        rif.req_valid = '0;
        rif.req_last  = '0;
        rif.req_wr    = '0;
        rif.req_addr  = '0;
        rif.req_wdat  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (accepted[r]) begin
                    accepted[r] = 1'b0;
                    if (beat_q[r].size() > 0) void'(beat_q[r].pop_front());
                end
                if (beat_q[r].size() > 0) begin
                    rif.req_valid[r]        = 1'b1;
                    rif.req_last[r]         = beat_q[r][0].last;
                    rif.req_wr[r*4 +: 4]    = beat_q[r][0].wr;
                    rif.req_addr[r*16 +: 16] = beat_q[r][0].addr;
                    rif.req_wdat[r*24 +: 24] = beat_q[r][0].wdat;
                end else begin
                    rif.req_valid[r] = 1'b0;
                    rif.req_last[r]  = 1'b0;
                end
            end
        end
    end

    // Handshake observer: a beat offered while ready is transferred at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                if (!rst && rif.req_valid[r] && rif.req_ready[r] && beat_q[r].size() > 0) begin
                    sb.push_back(expect_of(beat_q[r][0]));
                    accepted[r] = 1'b1;
                end
            end
        end
    end

    // Monitor: every panel write or drop must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (ctrl_en || drop_pulse)) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", {ctrl_en, drop_pulse, ctrl_wr, ctrl_addr, ctrl_wdat}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_write", {ctrl_en, drop_pulse, ctrl_wr, ctrl_addr, ctrl_wdat}, e);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((beat_q[0].size() != 0 || beat_q[1].size() != 0 || sb.size() != 0 ||
                rif.req_valid != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, "_drained"}, sb.size() + beat_q[0].size() + beat_q[1].size(), 64'd0);
        check({name, "_idle"}, grant, 64'd0);
    endtask

    task automatic wait_en(input string name, input int budget);
        int n = 0;
        while (!ctrl_en && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_en_seen"}, ctrl_en, 64'd1);
    endtask

    task automatic wait_grant(input string name, input logic [NR-1:0] g, input int budget);
        int n = 0;
        while (grant != g && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_grant_seen"}, grant, g);
    endtask

    initial begin
        int           eps [$];
        int           exp_eps [4];
        int           gap_err;
        int           n;
        logic [NR-1:0] prev;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl_en", ctrl_en, 64'd0);
        check("rst_ctrl_wr", ctrl_wr, 64'd0);
        check("rst_ctrl_addr", ctrl_addr, 64'd0);
        check("rst_ctrl_wdat", ctrl_wdat, 64'd0);
        check("rst_drop", drop_pulse, 64'd0);
        check("rst_grant", grant, 64'd0);
        rst = 1'b0;

        // Single 3-write burst from req0
        @(negedge clk);
        beat_q[0].push_back(mk(0, 24'h112233, 4'h7, 1'b0));
        beat_q[0].push_back(mk(1, 24'h445566, 4'h1, 1'b0));
        beat_q[0].push_back(mk(2, 24'h778899, 4'hF, 1'b1));
        @(negedge clk);
        check("t1_bubble_grant", grant, 64'd0);
        check("t1_bubble_ready", rif.req_ready, 64'd0);
        @(negedge clk);
        check("t1_lock_grant", grant, 64'd1);
        check("t1_lock_ready", rif.req_ready, 64'd1);
        check("t1_lock_en", ctrl_en, 64'd0);
        @(negedge clk);
        check("t1_w0", {ctrl_en, ctrl_addr}, {1'b1, 16'd0});
        @(negedge clk);
        check("t1_w1", {ctrl_en, ctrl_addr}, {1'b1, 16'd1});
        @(negedge clk);
        check("t1_w2", {ctrl_en, ctrl_addr}, {1'b1, 16'd2});
        check("t1_grant_released", grant, 64'd0);
        @(negedge clk);
        check("t1_en_low", ctrl_en, 64'd0);
        drain("t1", 20);

        // Alternation: pointer sits at req0, so req1 wins first
        beat_q[0].push_back(mk(10, 24'h0A0A0A, 4'h3, 1'b1));
        beat_q[0].push_back(mk(11, 24'h0B0B0B, 4'h3, 1'b1));
        beat_q[1].push_back(mk(20, 24'h141414, 4'h5, 1'b1));
        beat_q[1].push_back(mk(21, 24'h151515, 4'h5, 1'b1));
        exp_eps = '{2, 1, 2, 1};
        gap_err = 0;
        prev    = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (grant != '0 && prev == '0) eps.push_back(int'(grant));
            else if (grant != '0 && grant != prev) gap_err++;
            prev = grant;
        end
        check("t2_num_grants", eps.size(), 64'd4);
        for (int i = 0; i < 4; i++)
            check("t2_grant_order", (i < eps.size()) ? eps[i] : 0, exp_eps[i]);
        check("t2_idle_between", gap_err, 64'd0);
        drain("t2", 20);

        // Address range: 384 and 0xFFFF drop, 383 and a wr=0 write pass
        beat_q[1].push_back(mk(384, 24'hDEAD01, 4'h7, 1'b1));
        beat_q[1].push_back(mk(383, 24'hBEEF02, 4'hF, 1'b1));
        beat_q[1].push_back(mk(16'hFFFF, 24'hC0FFEE, 4'h2, 1'b1));
        beat_q[1].push_back(mk(5, 24'h000005, 4'h0, 1'b1));
        drain("t3", 40);

        // Stall timeout: req0 sends one non-last write then goes quiet
        beat_q[0].push_back(mk(7, 24'h070707, 4'h1, 1'b0));
        wait_grant("t4_req0", 2'b01, 10);
        beat_q[1].push_back(mk(8, 24'h080808, 4'h2, 1'b1));
        wait_en("t4_req0", 10);
        n = 0;
        while (grant == 2'b01 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("t4_stall_cycles", n, 64'd4);
        check("t4_revoked", grant, 64'd0);
        @(negedge clk);
        check("t4_req1_next", grant, 64'd2);
        drain("t4", 20);

        // Asynchronous reset in the middle of a req1 burst
        beat_q[0].push_back(mk(25, 24'h191919, 4'h1, 1'b1));
        for (int i = 0; i < 4; i++)
            beat_q[1].push_back(mk(30 + i, 24'hA00000 + i, 4'h6, (i == 3)));
        wait_grant("t5_req1", 2'b10, 20);
        wait_en("t5_req1", 10);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_en", ctrl_en, 64'd0);
        check("t5_async_addr", ctrl_addr, 64'd0);
        check("t5_async_wdat", ctrl_wdat, 64'd0);
        check("t5_async_wr", ctrl_wr, 64'd0);
        check("t5_async_grant", grant, 64'd0);
        beat_q[0].delete();
        beat_q[1].delete();
        sb.delete();
        accepted[0] = 1'b0;
        accepted[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        beat_q[0].push_back(mk(50, 24'h323232, 4'h7, 1'b1));
        beat_q[1].push_back(mk(51, 24'h333333, 4'h7, 1'b1));
        n = 0;
        while (grant == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_first_after_reset", grant, 64'd1);
        drain("t5", 20);

`ifdef LEDPANEL_ARB_STATS_EN
        // Two writes since reset already; add three in range and two drops
        beat_q[0].push_back(mk(40, 24'h000040, 4'h1, 1'b0));
        beat_q[0].push_back(mk(41, 24'h000041, 4'h1, 1'b0));
        beat_q[0].push_back(mk(42, 24'h000042, 4'h1, 1'b1));
        beat_q[0].push_back(mk(500, 24'h000500, 4'h1, 1'b1));
        beat_q[0].push_back(mk(1000, 24'h001000, 4'h1, 1'b1));
        drain("t6", 40);
        check("t6_stat_writes", stat_writes, 64'd5);
        check("t6_stat_drops", stat_drops, 64'd2);
        for (int i = 0; i < 70000; i++)
            beat_q[0].push_back(mk(i % 384, i, 4'h7, (i == 69999)));
        drain("t7", 75000);
        check("t7_stat_writes_sat", stat_writes, 64'd65535);
        check("t7_stat_drops", stat_drops, 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ledpanel_write_arbiter.md
Name: ledpanel_write_arbiter

Overview:
Shares the single LED panel colour-memory write port (ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat) between NUM_REQ write sources, e.g. the Ethernet frame receiver and the test-pattern generator. Each requester presents a burst of pixel writes with valid/ready/last; the arbiter grants round-robin and holds the grant for a whole burst. Writes outside the panel address range are dropped. A stall timeout stops a dead requester from holding the port.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
CHAINED, 3, panels in chain; valid pixel addresses are 0 .. CHAINED*128-1
TIMEOUT, 255, idle cycles with valid low before a held grant is revoked; 0 disables the timeout

Ports:
ctrl_clk  in  1  sole clock (panel write clock domain)
ctrl_rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester write valid
req_last  in  NUM_REQ  marks final write of a burst
req_wr  in  NUM_REQ*4  per-requester colour-plane enables (slice i = bits 4i+3:4i)
req_addr  in  NUM_REQ*16  per-requester pixel address
req_wdat  in  NUM_REQ*24  per-requester data [R][G][B]
req_ready  out  NUM_REQ  combinational: locked && grant[i]
ctrl_en  out  1  registered write strobe to panel memory
ctrl_wr  out  4  registered plane enables; bit 3 always 0
ctrl_addr  out  16  registered address
ctrl_wdat  out  24  registered data
grant  out  NUM_REQ  one-hot current owner; all-zero when IDLE
drop_pulse  out  1  one-cycle pulse when an out-of-range write is discarded

Behaviour:
- Reset (async, any time including mid-burst): state IDLE; grant=0; rr pointer=NUM_REQ-1, so requester 0 has first priority; timeout counter=0; ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat and drop_pulse are 0. A partial burst is abandoned with no further writes.
- IDLE: if any req_valid is high, pick the first valid index searching from pointer+1 upward with wrap. Register grant and go to LOCKED. This costs one bubble cycle; req_ready is 0 while IDLE.
- LOCKED: req_ready[g]=1 for the owner only. A transfer occurs when req_valid[g] && req_ready[g].
- Transfer, output stage (1-cycle latency):
  - ctrl_addr, ctrl_wdat and ctrl_wr[2:0] are loaded from slice g; ctrl_wr[3] is 0.
  - If addr < CHAINED*128: ctrl_en=1.
  - Otherwise: ctrl_en=0 and drop_pulse=1.
  - With no transfer: ctrl_en=0, drop_pulse=0, and the data registers hold their values.
- Transfer with req_last: next state IDLE, pointer<=g, grant cleared the next cycle. There is always at least one IDLE cycle between bursts.
- Timeout (TIMEOUT>0):
  - The counter clears on each transfer and on entry to LOCKED.
  - It increments each LOCKED cycle with req_valid[g]=0.
  - When it reaches TIMEOUT: go to IDLE and set pointer<=g, with no write that cycle.
- Non-owner req_valid is ignored. Requesters must hold valid/addr/data until ready.
- Address compare is unsigned over the full 16 bits.
- A burst may contain writes with req_wr=0. These are passed with ctrl_en=1 if in range and are harmless downstream.

Optional Feature:
LEDPANEL_ARB_STATS_EN
- Defined: adds outputs stat_writes (16-bit) and stat_drops (16-bit). These are saturating counters of accepted in-range writes and of dropped writes, cleared by ctrl_rst only. A write and a drop cannot occur in the same cycle.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req0 valid with a 3-write burst to addr 0,1,2 (last on 2): ctrl_en high on 3 consecutive cycles starting 2 cycles after valid; ctrl_addr 0,1,2; grant back to 0 after last.
- req0 and req1 valid together, each with 1-write bursts, repeated: grants alternate 0,1,0,1; each grant is preceded by an IDLE cycle.
- req1 write to addr 384 with CHAINED=3: ctrl_en=0, drop_pulse=1 for one cycle; addr 383 gives ctrl_en=1.
- TIMEOUT=4, req0 sends one non-last write then drops valid: grant revoked after exactly 4 stalled cycles; a waiting req1 is granted next.
- Assert ctrl_rst mid-burst: outputs 0 immediately (asynchronously); after release, requester 0 wins a simultaneous request.
- With LEDPANEL_ARB_STATS_EN: 5 valid writes + 2 out-of-range give stat_writes=5, stat_drops=2; 70000 writes saturate stat_writes at 65535.
